// File: rtl/alu_seq_ctrl_if.sv
// Front-panel bundle for alu_seq_ctrl.
// Carries the switch bus, the button levels, the chain select and everything
// the LEDs and the seven-segment driver need to see.
//   master : the panel side; drives data_in/enter/undo/chain, reads outputs
//   slave  : the controller; reads the panel, drives display/state/flags/valid
interface alu_seq_ctrl_if #(
    parameter int N = 16
) ();
    logic [N-1:0] data_in;
    logic         enter;
    logic         undo;
    logic         chain;
    logic [N-1:0] display;
    logic [1:0]   state_out;
    logic [4:0]   flags;
    logic         result_valid;

    modport master (
        output data_in, enter, undo, chain,
        input  display, state_out, flags, result_valid
    );

    modport slave (
        input  data_in, enter, undo, chain,
        output display, state_out, flags, result_valid
    );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Sequential ALU front-end: operand A, operand B and opcode are entered one
// after another from a single switch bus, stepped by enter/undo buttons.
// The result and its flags {N,Z,C,V,P} are registered and shown on the display.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   bus   : panel interface (slave side), see alu_seq_ctrl_if
//
// state   | meaning
// WAIT_A  | display follows switches; enter loads operand A
// WAIT_B  | display follows switches; enter loads B, undo back to WAIT_A
// WAIT_OP | display shows switch bits [2:0]; enter loads opcode
// SHOW    | result captured one cycle after entry and held on the display
module alu_seq_ctrl #(
    parameter int N = 16
) (
    input  logic          clk,
    input  logic          reset,
    alu_seq_ctrl_if.slave bus
);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        WAIT_A  = 2'b00,
        WAIT_B  = 2'b01,
        WAIT_OP = 2'b10,
        SHOW    = 2'b11
    } state_t;

    state_t       state_q, state_d;
    logic         enter_q, undo_q;
    logic         enter_p, undo_p;
    logic [N-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]   op_q, op_d;
    logic [4:0]   flags_q, flags_d;
    logic         cap_q, cap_d;
    logic         valid_q, valid_d;

    logic [N-1:0] alu_res;
    logic         alu_c, alu_v;
    logic [N:0]   sum, diff;
    logic [SW-1:0] shamt;

    assign enter_p = bus.enter & ~enter_q;
    assign undo_p  = bus.undo  & ~undo_q;

    always_comb begin
        sum     = {1'b0, a_q} + {1'b0, b_q};
        diff    = {1'b0, a_q} - {1'b0, b_q};
        shamt   = b_q[SW-1:0];
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (op_q)
            3'b000: begin
                alu_res = sum[N-1:0];
                alu_c   = sum[N];
                alu_v   = (a_q[N-1] == b_q[N-1]) && (sum[N-1] != a_q[N-1]);
            end
            3'b001: begin
                alu_res = diff[N-1:0];
                // diff[N] is the borrow, so carry means A >= B
                alu_c   = ~diff[N];
                alu_v   = (a_q[N-1] != b_q[N-1]) && (diff[N-1] != a_q[N-1]);
            end
            3'b010:  alu_res = a_q | b_q;
            3'b011:  alu_res = a_q & b_q;
            3'b100:  alu_res = a_q ^ b_q;
            3'b101:  alu_res = a_q << shamt;
            3'b110:  alu_res = a_q >> shamt;
            default: alu_res = a_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        res_d   = res_q;
        flags_d = flags_q;
        cap_d   = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (enter_p) begin
                    a_d     = bus.data_in;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (undo_p) begin
                    state_d = WAIT_A;
                end else if (enter_p) begin
                    b_d     = bus.data_in;
                    state_d = WAIT_OP;
                end
            end
            WAIT_OP: begin
                if (undo_p) begin
                    state_d = WAIT_B;
                end else if (enter_p) begin
                    op_d    = bus.data_in[2:0];
                    state_d = SHOW;
                    cap_d   = 1'b1;
                end
            end
            default: begin
                // ALU sees the new opcode only after reg_op has loaded
                if (cap_q) begin
                    res_d   = alu_res;
                    flags_d = {alu_res[N-1], (alu_res == '0), alu_c, alu_v, ^alu_res};
                end
                if (undo_p) begin
                    state_d = WAIT_OP;
                end else if (enter_p) begin
                    if (bus.chain) begin
                        a_d     = res_q;
                        state_d = WAIT_B;
                    end else begin
                        state_d = WAIT_A;
                    end
                end
            end
        endcase
        valid_d = (state_d == SHOW) && (valid_q || cap_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= WAIT_A;
            enter_q <= 1'b0;
            undo_q  <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= 3'b000;
            res_q   <= '0;
            flags_q <= 5'b0;
            cap_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            enter_q <= bus.enter;
            undo_q  <= bus.undo;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            cap_q   <= cap_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin
        case (state_q)
            WAIT_OP: bus.display = {{(N-3){1'b0}}, bus.data_in[2:0]};
            SHOW:    bus.display = res_q;
            default: bus.display = bus.data_in;
        endcase
    end

    assign bus.state_out    = state_q;
    assign bus.flags        = flags_q;
    assign bus.result_valid = valid_q;
endmodule
